// File: rtl/nn_host_regs.sv
// Avalon-MM register host that loads input words, launches the inference core, and collects its results.
// Latency: reads return one cycle after the read strobe. The core request is issued one cycle after the START write.
// Backpressure: the request is held until net_in_ready. Results are accepted only in WAIT. The bus never stalls.
//
// Ports:
//   clk, reset            : clock; synchronous active-high reset
//   avs_s0_*              : Avalon-MM slave (word address, fixed read latency 1)
//   net_in/net_in_valid   : request to core; net_in_ready is the core's accept
//   net_out/net_out_valid : single-cycle result pulse from core
//   irq                   : level interrupt, present only when NN_HOST_IRQ_EN is defined
//
// Address map: 0 CTRL (wo: bit0 START, bit1 CLR), 1 STATUS (bit0 busy, bit1 done,
// bit2 timeout, [31:16] run_count), 2.. inputs (rw), then results (ro), then
// IRQ_MASK (NN_HOST_IRQ_EN only). STATUS layout assumes DATA_W >= 32.
module nn_host_regs #(
   parameter int DATA_W  = 32,
   parameter int NUM_IN  = 2,
   parameter int NUM_OUT = 1,
   parameter int ADDR_W  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [ADDR_W-1:0]         avs_s0_address,
   input  logic                      avs_s0_read,
   input  logic                      avs_s0_write,
   input  logic [DATA_W-1:0]         avs_s0_writedata,
   output logic [DATA_W-1:0]         avs_s0_readdata,
   output logic                      avs_s0_readdatavalid,
   output logic [NUM_IN*DATA_W-1:0]  net_in,
   output logic                      net_in_valid,
   input  logic                      net_in_ready,
   input  logic [NUM_OUT*DATA_W-1:0] net_out,
   input  logic                      net_out_valid
`ifdef NN_HOST_IRQ_EN
   ,
   output logic                      irq
`endif
);

   localparam int TMR_W    = $clog2(TIMEOUT);
   localparam int RES_BASE = 2 + NUM_IN;
   localparam int MASK_ADR = 2 + NUM_IN + NUM_OUT;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t              state;
   logic [DATA_W-1:0]   in_regs  [NUM_IN];
   logic [DATA_W-1:0]   res_regs [NUM_OUT];
   logic                done;
   logic                timeout;
   logic [15:0]         run_count;
   logic [TMR_W-1:0]    timer;
   logic [DATA_W-1:0]   rd_mux;
   logic [31:0]         addr_i;
   logic                busy;
   logic                idle;
   logic                start_cmd;
   logic                clr_cmd;
   logic                res_evt;
   logic                to_evt;

   // Widened address so that a register index equal to 2**ADDR_W can never
   // alias a low address after truncation.
   assign addr_i    = 32'(avs_s0_address);
   assign busy      = (state != S_IDLE);
   assign idle      = !busy;
   assign start_cmd = avs_s0_write && (addr_i == 32'd0) && avs_s0_writedata[0];
   assign clr_cmd   = avs_s0_write && (addr_i == 32'd0) && avs_s0_writedata[1];

   // A result arriving on the last timer cycle takes precedence over the timeout.
   assign res_evt = (state == S_WAIT) && net_out_valid;
   assign to_evt  = (state == S_WAIT) && !net_out_valid && (timer == TMR_W'(TIMEOUT - 1));

   genvar g;
   generate
      for (g = 0; g < NUM_IN; g++) begin : g_net_in
         assign net_in[g*DATA_W +: DATA_W] = in_regs[g];
      end
   endgenerate

`ifdef NN_HOST_IRQ_EN
   logic irq_pending;
   logic irq_mask;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_pending <= 1'b0;
         irq_mask    <= 1'b0;
         irq         <= 1'b0;
      end else begin
         if (res_evt || to_evt) begin
            irq_pending <= 1'b1;
         end else if (idle && (start_cmd || clr_cmd)) begin
            irq_pending <= 1'b0;
         end
         if (avs_s0_write && (addr_i == 32'(MASK_ADR))) begin
            irq_mask <= avs_s0_writedata[0];
         end
         irq <= irq_pending && irq_mask;
      end
   end
`endif

   // Read mux uses current register values, so a same-cycle write is not
   // visible to the read it collides with.
   always_comb begin
      rd_mux = '0;
      if (addr_i == 32'd1) begin
         rd_mux[0]     = busy;
         rd_mux[1]     = done;
         rd_mux[2]     = timeout;
         rd_mux[31:16] = run_count;
      end
      for (int k = 0; k < NUM_IN; k++) begin
         if (addr_i == 32'(2 + k)) begin
            rd_mux = in_regs[k];
         end
      end
      for (int k = 0; k < NUM_OUT; k++) begin
         if (addr_i == 32'(RES_BASE + k)) begin
            rd_mux = res_regs[k];
         end
      end
`ifdef NN_HOST_IRQ_EN
      if (addr_i == 32'(MASK_ADR)) begin
         rd_mux    = '0;
         rd_mux[0] = irq_mask;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state                <= S_IDLE;
         net_in_valid         <= 1'b0;
         done                 <= 1'b0;
         timeout              <= 1'b0;
         run_count            <= '0;
         timer                <= '0;
         avs_s0_readdata      <= '0;
         avs_s0_readdatavalid <= 1'b0;
         for (int k = 0; k < NUM_IN; k++) begin
            in_regs[k] <= '0;
         end
         for (int k = 0; k < NUM_OUT; k++) begin
            res_regs[k] <= '0;
         end
      end else begin
         avs_s0_readdatavalid <= avs_s0_read;
         avs_s0_readdata      <= avs_s0_read ? rd_mux : '0;

         // Inputs are frozen while busy so the request vector cannot change mid-run.
         if (avs_s0_write && idle) begin
            for (int k = 0; k < NUM_IN; k++) begin
               if (addr_i == 32'(2 + k)) begin
                  in_regs[k] <= avs_s0_writedata;
               end
            end
         end

         case (state)
            S_IDLE: begin
               if (start_cmd || clr_cmd) begin
                  done    <= 1'b0;
                  timeout <= 1'b0;
               end
               if (start_cmd) begin
                  state        <= S_ISSUE;
                  net_in_valid <= 1'b1;
               end
            end
            S_ISSUE: begin
               if (net_in_ready) begin
                  state        <= S_WAIT;
                  net_in_valid <= 1'b0;
                  timer        <= '0;
               end
            end
            S_WAIT: begin
               if (res_evt) begin
                  for (int k = 0; k < NUM_OUT; k++) begin
                     res_regs[k] <= net_out[k*DATA_W +: DATA_W];
                  end
                  done      <= 1'b1;
                  run_count <= run_count + 16'd1;
                  state     <= S_IDLE;
               end else if (to_evt) begin
                  timeout <= 1'b1;
                  state   <= S_IDLE;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            default: begin
               state        <= S_IDLE;
               net_in_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nn_host_regs.sv
// Directed testbench for nn_host_regs (TIMEOUT=16, NUM_IN=2, NUM_OUT=1).
// Inputs are driven 1ns after the rising edge and outputs are sampled there too.
// Address map under test: 0 CTRL, 1 STATUS, 2/3 inputs, 4 result, 5 IRQ_MASK.
module tb_nn_host_regs;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  avs_s0_address;
   logic        avs_s0_read;
   logic        avs_s0_write;
   logic [31:0] avs_s0_writedata;
   logic [31:0] avs_s0_readdata;
   logic        avs_s0_readdatavalid;
   logic [63:0] net_in;
   logic        net_in_valid;
   logic        net_in_ready;
   logic [31:0] net_out;
   logic        net_out_valid;
`ifdef NN_HOST_IRQ_EN
   logic        irq;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nn_host_regs #(
      .DATA_W (32),
      .NUM_IN (2),
      .NUM_OUT(1),
      .ADDR_W (4),
      .TIMEOUT(16)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .avs_s0_address      (avs_s0_address),
      .avs_s0_read         (avs_s0_read),
      .avs_s0_write        (avs_s0_write),
      .avs_s0_writedata    (avs_s0_writedata),
      .avs_s0_readdata     (avs_s0_readdata),
      .avs_s0_readdatavalid(avs_s0_readdatavalid),
      .net_in              (net_in),
      .net_in_valid        (net_in_valid),
      .net_in_ready        (net_in_ready),
      .net_out             (net_out),
      .net_out_valid       (net_out_valid)
`ifdef NN_HOST_IRQ_EN
      ,
      .irq                 (irq)
`endif
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      avs_s0_address   = a;
      avs_s0_writedata = d;
      avs_s0_write     = 1'b1;
      tick();
      avs_s0_write     = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
      avs_s0_address = a;
      avs_s0_read    = 1'b1;
      tick();
      avs_s0_read    = 1'b0;
      check_val({tag, "_rdv"}, 64'(avs_s0_readdatavalid), 64'd1);
      check_val(tag, 64'(avs_s0_readdata), 64'(exp));
   endtask

   task automatic pulse_result(input logic [31:0] d);
      net_out       = d;
      net_out_valid = 1'b1;
      tick();
      net_out_valid = 1'b0;
      net_out       = '0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset            = 1'b1;
      avs_s0_address   = '0;
      avs_s0_read      = 1'b0;
      avs_s0_write     = 1'b0;
      avs_s0_writedata = '0;
      net_in_ready     = 1'b0;
      net_out          = '0;
      net_out_valid    = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // Reset state: outputs idle, every address reads 0 with latency 1.
      check_val("rst_niv", 64'(net_in_valid), 64'd0);
      check_val("rst_rdv", 64'(avs_s0_readdatavalid), 64'd0);
      check_val("rst_net_in", net_in, 64'd0);
      for (int a = 0; a < 16; a++) begin
         rd_chk("rst_rd", 4'(a), 32'd0);
      end
      tick();
      check_val("rdv_drop", 64'(avs_s0_readdatavalid), 64'd0);

      // Normal run: ready 3 cycles into the request, result 5 cycles after handshake.
      bus_write(4'd2, 32'h11);
      bus_write(4'd3, 32'h22);
      bus_write(4'd0, 32'h1);
      check_val("issue_niv", 64'(net_in_valid), 64'd1);
      check_val("issue_net_in", net_in, 64'h00000022_00000011);
      repeat (3) tick();
      check_val("hold_niv", 64'(net_in_valid), 64'd1);
      net_in_ready = 1'b1;
      tick();
      net_in_ready = 1'b0;
      check_val("hs_niv", 64'(net_in_valid), 64'd0);
      rd_chk("wait_status", 4'd1, 32'h0000_0001);
      repeat (3) tick();
      check_val("wait_net_in", net_in, 64'h00000022_00000011);
      pulse_result(32'hABCD);
      rd_chk("done_status", 4'd1, 32'h0001_0002);
      rd_chk("res_abcd", 4'd4, 32'hABCD);
      tick();
      check_val("rd_zero", 64'(avs_s0_readdata), 64'd0);

      // Same-cycle read and write: the read returns the pre-write value.
      avs_s0_address   = 4'd3;
      avs_s0_writedata = 32'h99;
      avs_s0_read      = 1'b1;
      avs_s0_write     = 1'b1;
      tick();
      avs_s0_read  = 1'b0;
      avs_s0_write = 1'b0;
      check_val("rw_old", 64'(avs_s0_readdata), 64'h22);
      rd_chk("rw_new", 4'd3, 32'h99);
      bus_write(4'd3, 32'h22);

      // Result pulse outside WAIT is ignored.
      pulse_result(32'hDEAD);
      rd_chk("stray_res", 4'd4, 32'hABCD);
      rd_chk("stray_status", 4'd1, 32'h0001_0002);

      // Timeout exactly 16 cycles after handshake; result register untouched.
      net_in_ready = 1'b1;
      bus_write(4'd0, 32'h1);
      tick();
      net_in_ready = 1'b0;
      repeat (15) tick();
      rd_chk("to_before", 4'd1, 32'h0001_0001);
      rd_chk("to_after", 4'd1, 32'h0001_0004);
      rd_chk("to_res", 4'd4, 32'hABCD);
      bus_write(4'd0, 32'h2);
      rd_chk("clr_status", 4'd1, 32'h0001_0000);

      // Result on the very cycle the timer expires wins over the timeout.
      net_in_ready = 1'b1;
      bus_write(4'd0, 32'h1);
      tick();
      net_in_ready = 1'b0;
      repeat (15) tick();
      pulse_result(32'h1234);
      rd_chk("edge_status", 4'd1, 32'h0002_0002);
      rd_chk("edge_res", 4'd4, 32'h1234);

      // START+CLR together, then input write and START while busy are ignored.
      bus_write(4'd0, 32'h3);
      rd_chk("stclr_status", 4'd1, 32'h0002_0001);
      bus_write(4'd2, 32'h55);
      bus_write(4'd0, 32'h1);
      check_val("busy_net_in", net_in, 64'h00000022_00000011);
      net_in_ready = 1'b1;
      tick();
      net_in_ready = 1'b0;
      repeat (2) tick();
      pulse_result(32'h77);
      rd_chk("one_run_status", 4'd1, 32'h0003_0002);
      rd_chk("in0_kept", 4'd2, 32'h11);
      repeat (5) tick();
      rd_chk("no_rerun", 4'd1, 32'h0003_0002);
      check_val("no_rerun_niv", 64'(net_in_valid), 64'd0);

`ifdef NN_HOST_IRQ_EN
      // Interrupt: masked-in run raises irq one cycle after done; CLR drops it.
      bus_write(4'd5, 32'h1);
      rd_chk("mask_rd", 4'd5, 32'h1);
      net_in_ready = 1'b1;
      bus_write(4'd0, 32'h1);
      tick();
      net_in_ready = 1'b0;
      pulse_result(32'h5);
      check_val("irq_same", 64'(irq), 64'd0);
      tick();
      check_val("irq_set", 64'(irq), 64'd1);
      bus_write(4'd0, 32'h2);
      tick();
      check_val("irq_clr", 64'(irq), 64'd0);
      bus_write(4'd5, 32'h0);
      net_in_ready = 1'b1;
      bus_write(4'd0, 32'h1);
      tick();
      net_in_ready = 1'b0;
      pulse_result(32'h6);
      repeat (3) tick();
      check_val("irq_masked", 64'(irq), 64'd0);
      bus_write(4'd5, 32'h1);
`endif

      // Reset during WAIT aborts; a later result pulse is not captured.
      bus_write(4'd2, 32'h5A);
      net_in_ready = 1'b1;
      bus_write(4'd0, 32'h1);
      tick();
      net_in_ready = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("mid_rst_niv", 64'(net_in_valid), 64'd0);
      check_val("mid_rst_net_in", net_in, 64'd0);
      pulse_result(32'hBEEF);
      for (int a = 0; a < 16; a++) begin
         rd_chk("mid_rst_rd", 4'(a), 32'd0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
